// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and constants for the FC result framer
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        SEQ  = 3'd2,
        DATA = 3'd3,
        CHK  = 3'd4
    } framer_state_t;

    localparam logic [7:0] SOF_BYTE_DEF  = 8'hA5;
    localparam int         FRAME_HDR_LEN = 2;

endpackage

// File: rtl/fc_result_framer.sv
// rtl/fc_result_framer.sv - frames FC result vectors into SOF/SEQ/DATA/CHK byte packets for UART TX
module fc_result_framer
    import fc_pkg::*;
#(
    parameter int         DIM_OUTPUT = 8,
    parameter int         OUTPUT_W   = 8,
    parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OUTPUT_W-1:0] in_dat [DIM_OUTPUT],
    input  logic                in_valid,
    output logic [7:0]          tx_data,
    output logic                tx_data_valid,
    input  logic                tx_data_ready,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          drop_cnt,
    output logic                overflow
);

    // Index counter has one spare bit so the last-index compare never wraps.
    localparam int CW = $clog2(DIM_OUTPUT) + 1;
    localparam int AW = (DIM_OUTPUT > 1) ? $clog2(DIM_OUTPUT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM_OUTPUT - 1);

    if (OUTPUT_W != 8) begin : g_width_check
        $error("fc_result_framer: OUTPUT_W must be 8");
    end
    if (DIM_OUTPUT < 1) begin : g_dim_check
        $error("fc_result_framer: DIM_OUTPUT must be at least 1");
    end

    framer_state_t       state;
    logic [CW-1:0]       idx;
    logic [7:0]          seq;
    logic [7:0]          chk;
    logic [OUTPUT_W-1:0] act  [DIM_OUTPUT];
    logic [OUTPUT_W-1:0] pend [DIM_OUTPUT];
    logic                pend_vld;

    logic                xfer;
    logic                ct;
    logic [CW-1:0]       idx_nxt;
    logic [OUTPUT_W-1:0] cur_byte;
    logic [OUTPUT_W-1:0] nxt_byte;

    assign xfer     = tx_data_valid & tx_data_ready;
    assign ct       = xfer & (state == CHK);
    assign idx_nxt  = idx + CW'(1);
    assign cur_byte = act[idx[AW-1:0]];
    assign nxt_byte = act[idx_nxt[AW-1:0]];
    assign busy     = (state != IDLE) | pend_vld;

    // Byte sequencer: walks SOF -> SEQ -> DATA -> CHK, advancing only on a transfer,
    // and preloads the next byte into the registered tx_data on each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            seq           <= '0;
            chk           <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= ct;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state         <= SOF;
                        tx_data       <= SOF_BYTE;
                        tx_data_valid <= 1'b1;
                    end
                end
                SOF: begin
                    if (xfer) begin
                        state   <= SEQ;
                        tx_data <= seq;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        state   <= DATA;
                        idx     <= '0;
                        chk     <= seq;
                        tx_data <= act[0];
                    end
                end
                DATA: begin
                    if (xfer) begin
                        chk <= chk ^ cur_byte;
                        if (idx == LAST_IDX) begin
                            state   <= CHK;
                            tx_data <= chk ^ cur_byte;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= nxt_byte;
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        seq <= seq + 8'd1;
                        // A waiting or simultaneously arriving vector starts a new frame with no gap.
                        if (pend_vld || in_valid) begin
                            state   <= SOF;
                            tx_data <= SOF_BYTE;
                        end else begin
                            state         <= IDLE;
                            tx_data_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    tx_data_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bank management: capture into ACTIVE or PENDING, promote PENDING at frame end,
    // and count vectors that find both banks occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM_OUTPUT; i++) begin
                act[i]  <= '0;
                pend[i] <= '0;
            end
            pend_vld <= 1'b0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                act <= in_dat;
            end
        end else if (ct) begin
            if (pend_vld) begin
                act      <= pend;
                pend_vld <= in_valid;
                if (in_valid) begin
                    pend <= in_dat;
                end
            end else if (in_valid) begin
                act <= in_dat;
            end
        end else if (in_valid) begin
            if (!pend_vld) begin
                pend     <= in_dat;
                pend_vld <= 1'b1;
            end else begin
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                overflow <= 1'b1;
            end
        end
    end

endmodule
